// File: rtl/dff_pipe_sl.sv
// Enable-gated, synchronously resettable pipeline of master-slave DFFs
// built from nmos/pmos switches only; a valid bit travels with each word.
module dff_pipe_sl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_val,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_val,
  output logic [WIDTH-1:0] out_data
);

  // Bit WIDTH of every stage is the valid flag; bits below are data.
  localparam int unsigned N = WIDTH + 1;

  supply1 vdd;
  supply0 gnd;

  wire [N-1:0] in_bus;
  assign in_bus = {in_val, in_data};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    wire ck_b, ck, en_b;

    // Local clock buffer pair and enable inverter, shared by all bits of the stage.
    pmos u_p_ckb (ck_b, vdd, clk);
    nmos u_n_ckb (ck_b, gnd, clk);
    pmos u_p_ck  (ck,   vdd, ck_b);
    nmos u_n_ck  (ck,   gnd, ck_b);
    pmos u_p_enb (en_b, vdd, en);
    nmos u_n_enb (en_b, gnd, en);

    for (genvar i = 0; i < N; i++) begin : g_bit
      wire mx, nd, nm, d, m, mb, mf, s, sb, q;

      // Enable mux: upstream value when en=1, own q when en=0.
      if (k == 0) begin : g_head
        nmos u_n_up (mx, in_bus[i], en);
        pmos u_p_up (mx, in_bus[i], en_b);
      end else begin : g_link
        nmos u_n_up (mx, g_stage[k-1].g_bit[i].q, en);
        pmos u_p_up (mx, g_stage[k-1].g_bit[i].q, en_b);
      end
      nmos u_n_hold (mx, q, en_b);
      pmos u_p_hold (mx, q, en);

      // d = rst_n & mx as NAND followed by an inverter.
      pmos u_p_nand_r (nd, vdd, rst_n);
      pmos u_p_nand_m (nd, vdd, mx);
      nmos u_n_nand_r (nd, nm,  rst_n);
      nmos u_n_nand_m (nm, gnd, mx);
      pmos u_p_dinv   (d,  vdd, nd);
      nmos u_n_dinv   (d,  gnd, nd);

      // Master: transparent while clk=0, held by feedback while clk=1.
      nmos u_n_min  (m,  d,   ck_b);
      pmos u_p_min  (m,  d,   ck);
      pmos u_p_minv (mb, vdd, m);
      nmos u_n_minv (mb, gnd, m);
      pmos u_p_mbuf (mf, vdd, mb);
      nmos u_n_mbuf (mf, gnd, mb);
      nmos u_n_mfb  (m,  mf,  ck);
      pmos u_p_mfb  (m,  mf,  ck_b);

      // Slave: transparent while clk=1, held by feedback while clk=0.
      nmos u_n_sin  (s,  mf,  ck);
      pmos u_p_sin  (s,  mf,  ck_b);
      pmos u_p_sinv (sb, vdd, s);
      nmos u_n_sinv (sb, gnd, s);
      pmos u_p_sbuf (q,  vdd, sb);
      nmos u_n_sbuf (q,  gnd, sb);
      nmos u_n_sfb  (s,  q,   ck_b);
      pmos u_p_sfb  (s,  q,   ck);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_out
    assign out_data[i] = g_stage[DEPTH-1].g_bit[i].q;
  end
  assign out_val = g_stage[DEPTH-1].g_bit[WIDTH].q;

endmodule

// File: tb/tb_dff_pipe_sl.sv
// Bench for dff_pipe_sl: three instances (1x1, 8x4, 16x7) checked every
// cycle against queue-based delay-line models, plus directed scenarios.
module tb_dff_pipe_sl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        in_val = 1'b0;
  logic [15:0] din = '0;

  logic        o1_val, o8_val, o16_val;
  logic [0:0]  o1_data;
  logic [7:0]  o8_data;
  logic [15:0] o16_data;

  int n_checks = 0;
  int n_errors = 0;

  localparam int          DEP  [3] = '{1, 4, 7};
  localparam logic [15:0] MASK [3] = '{16'h0001, 16'h00FF, 16'hFFFF};

  // Each model entry is {valid, data[15:0]}; back of queue is the output.
  logic [16:0] mdl [3][$];

  always #5 clk = ~clk;

  dff_pipe_sl #(.WIDTH(1), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_val(in_val), .in_data(din[0:0]),
    .out_val(o1_val), .out_data(o1_data)
  );

  dff_pipe_sl #(.WIDTH(8), .DEPTH(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_val(in_val), .in_data(din[7:0]),
    .out_val(o8_val), .out_data(o8_data)
  );

  dff_pipe_sl #(.WIDTH(16), .DEPTH(7)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_val(in_val), .in_data(din),
    .out_val(o16_val), .out_data(o16_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, update models, compare on the falling edge.
  task automatic tick(input logic r, input logic e, input logic v, input logic [15:0] d);
    logic [16:0] obs [3];
    logic [16:0] exp;
    rst_n  = r;
    en     = e;
    in_val = v;
    din    = d;
    @(posedge clk);
    for (int u = 0; u < 3; u++) begin
      if (!r) begin
        mdl[u].delete();
        for (int j = 0; j < DEP[u]; j++) mdl[u].push_front(17'd0);
      end else if (e && mdl[u].size() != 0) begin
        mdl[u].push_front({v, d & MASK[u]});
        void'(mdl[u].pop_back());
      end
    end
    @(negedge clk);
    obs[0] = {o1_val, 15'd0, o1_data};
    obs[1] = {o8_val, 8'd0, o8_data};
    obs[2] = {o16_val, o16_data};
    for (int u = 0; u < 3; u++) begin
      if (mdl[u].size() != 0) begin
        exp = mdl[u][mdl[u].size()-1];
        check_eq($sformatf("model%0d val", u), {31'd0, obs[u][16]}, {31'd0, exp[16]});
        check_eq($sformatf("model%0d data", u), {16'd0, obs[u][15:0]}, {16'd0, exp[15:0]});
      end
    end
  endtask

  initial begin
    // Reset for two edges with inputs all ones.
    tick(1'b0, 1'b1, 1'b1, 16'hFFFF);
    check_eq("reset val", {31'd0, o8_val}, 32'd0);
    check_eq("reset data", {24'd0, o8_data}, 32'd0);
    tick(1'b0, 1'b1, 1'b1, 16'hFFFF);
    check_eq("reset2 data", {24'd0, o8_data}, 32'd0);

    // Stream 1..8: word i appears after edge i+3.
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b1, 1'b1, 16'(i));
      if (i >= 4) begin
        check_eq("stream val", {31'd0, o8_val}, 32'd1);
        check_eq("stream data", {24'd0, o8_data}, 32'(i - 3));
      end
    end

    // Stall: A5 loaded, three held edges with changing inputs, then drain.
    tick(1'b1, 1'b1, 1'b1, 16'h00A5);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 16'($urandom));
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    check_eq("stall val", {31'd0, o8_val}, 32'd1);
    check_eq("stall data", {24'd0, o8_data}, 32'h0000_00A5);
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    check_eq("stall once", {31'd0, o8_val}, 32'd0);

    // Mid-stream reset flushes three in-flight entries.
    tick(1'b1, 1'b1, 1'b1, 16'h0011);
    tick(1'b1, 1'b1, 1'b1, 16'h0022);
    tick(1'b1, 1'b1, 1'b1, 16'h0033);
    tick(1'b0, 1'b1, 1'b1, 16'h0044);
    check_eq("flush val", {31'd0, o8_val}, 32'd0);
    check_eq("flush data", {24'd0, o8_data}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 1'b0, 16'h0000);
      check_eq("flush drain", {31'd0, o8_val}, 32'd0);
    end

    // Reset wins over a held pipe.
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b1, 16'hC35A);
    tick(1'b0, 1'b0, 1'b1, 16'h7777);
    check_eq("rst_vs_en val16", {31'd0, o16_val}, 32'd0);
    check_eq("rst_vs_en data16", {16'd0, o16_data}, 32'd0);
    check_eq("rst_vs_en val1", {31'd0, o1_val}, 32'd0);

    // Random sweep with occasional reset.
    for (int i = 0; i < 500; i++) begin
      tick(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
